// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes, FSM states,
// and the legality / byte-enable decode used by the LSU.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} lsu_state_e;

   // Legal width code for the direction, and naturally aligned for that width.
   function automatic logic lsu_legal(input logic [2:0] f3, input logic we,
                                      input logic [1:0] off);
      logic ok;
      case (f3)
         F3_B:    ok = 1'b1;
         F3_H:    ok = ~off[0];
         F3_W:    ok = (off == 2'b00);
         F3_BU:   ok = ~we;
         F3_HU:   ok = ~we & ~off[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] lsu_be(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] be;
      case (f3)
         F3_B:    be = 4'b0001 << off;
         F3_H:    be = off[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] data_o
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = rdata_i[{off_i, 3'b000} +: 8];
      w_half = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (funct3_i)
         F3_B:    data_o = {{24{w_byte[7]}}, w_byte};
         F3_BU:   data_o = {24'h000000, w_byte};
         F3_H:    data_o = {{16{w_half[15]}}, w_half};
         F3_HU:   data_o = {16'h0000, w_half};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: runs one access on a req/gnt/rvalid bus, stalls the
// pipeline meanwhile, and returns aligned load data with a bounded wait.
module mem_stage_lsu
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] RESET_DATA     = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   input  logic        mem_we_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        stall_o,
   output logic [31:0] data_r_o,
   output logic        data_valid_o,
   output logic        acc_err_o,
   output logic        timeout_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   output logic [3:0]  bus_be_o,
   input  logic        bus_gnt_i,
   input  logic        bus_rvalid_i,
   input  logic [31:0] bus_rdata_i
);

   localparam int unsigned    CntW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   lsu_state_e      r_state;
   logic [31:0]     r_addr;
   logic [2:0]      r_f3;
   logic            r_we;
   logic [31:0]     r_wdata;
   logic [CntW-1:0] r_cnt;
   logic [31:0]     r_data;
   logic            r_data_valid;
   logic            r_acc_err;
   logic            r_timeout;

   logic            w_legal;
   logic            w_req;
   logic            w_expired;
   logic [31:0]     w_load_data;
   logic [31:0]     w_store_data;

   assign w_legal   = lsu_legal(funct3_i, mem_we_i, addr_i[1:0]);
   assign w_req     = (r_state == REQ);
   // >= so a load granted on the last REQ cycle still gets one WAIT_R cycle.
   assign w_expired = (r_cnt >= CntLast);

   lsu_load_align u_align (
      .funct3_i (r_f3),
      .off_i    (r_addr[1:0]),
      .rdata_i  (bus_rdata_i),
      .data_o   (w_load_data)
   );

   always_comb begin
      case (r_f3)
         F3_B:    w_store_data = {4{r_wdata[7:0]}};
         F3_H:    w_store_data = {2{r_wdata[15:0]}};
         default: w_store_data = r_wdata;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= IDLE;
         r_addr       <= '0;
         r_f3         <= '0;
         r_we         <= 1'b0;
         r_wdata      <= '0;
         r_cnt        <= '0;
         r_data       <= RESET_DATA;
         r_data_valid <= 1'b0;
         r_acc_err    <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_data_valid <= 1'b0;
         r_acc_err    <= 1'b0;
         r_timeout    <= 1'b0;
         case (r_state)
            IDLE: begin
               if (req_valid_i) begin
                  if (w_legal) begin
                     r_addr  <= addr_i;
                     r_f3    <= funct3_i;
                     r_we    <= mem_we_i;
                     r_wdata <= wdata_i;
                     r_cnt   <= '0;
                     r_state <= REQ;
                  end else begin
                     r_acc_err <= 1'b1;
                  end
               end
            end
            REQ: begin
               r_cnt <= r_cnt + 1'b1;
               if (bus_gnt_i) begin
                  r_state <= r_we ? DONE : WAIT_R;
               end else if (w_expired) begin
                  r_state   <= DONE;
                  r_timeout <= 1'b1;
                  r_data    <= RESET_DATA;
               end
            end
            WAIT_R: begin
               r_cnt <= r_cnt + 1'b1;
               if (bus_rvalid_i) begin
                  r_data       <= w_load_data;
                  r_data_valid <= 1'b1;
                  r_state      <= DONE;
               end else if (w_expired) begin
                  r_state   <= DONE;
                  r_timeout <= 1'b1;
                  r_data    <= RESET_DATA;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign stall_o      = ((r_state == IDLE) & req_valid_i & w_legal) | w_req |
                         (r_state == WAIT_R);
   assign data_r_o     = r_data;
   assign data_valid_o = r_data_valid;
   assign acc_err_o    = r_acc_err;
   assign timeout_o    = r_timeout;
   assign bus_req_o    = w_req;
   assign bus_we_o     = w_req & r_we;
   assign bus_addr_o   = w_req ? {r_addr[31:2], 2'b00} : 32'h0;
   assign bus_wdata_o  = (w_req & r_we) ? w_store_data : 32'h0;
   assign bus_be_o     = (w_req & r_we) ? lsu_be(r_f3, r_addr[1:0]) : 4'b0000;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomised bench for mem_stage_lsu: a transaction-level model predicts every
// output cycle by cycle; directed cases pin the model with literal values.
module tb_mem_stage_lsu;

   localparam int T = 8;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0, mem_we_i = 1'b0;
   logic [2:0]  funct3_i = 3'b0;
   logic [31:0] addr_i = 32'h0, wdata_i = 32'h0;
   logic        stall_o, data_valid_o, acc_err_o, timeout_o;
   logic [31:0] data_r_o;
   logic        bus_req_o, bus_we_o;
   logic [31:0] bus_addr_o, bus_wdata_o;
   logic [3:0]  bus_be_o;
   logic        bus_gnt_i = 1'b0, bus_rvalid_i = 1'b0;
   logic [31:0] bus_rdata_i = 32'h0;

   mem_stage_lsu #(.TIMEOUT_CYCLES(T), .RESET_DATA(32'h0)) dut (
      .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .mem_we_i(mem_we_i),
      .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o),
      .data_r_o(data_r_o), .data_valid_o(data_valid_o), .acc_err_o(acc_err_o),
      .timeout_o(timeout_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
      .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
      .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   // Expected outputs for the current cycle, set by the driver after each posedge.
   logic        e_chk = 1'b0;
   logic        e_stall, e_req, e_dv, e_err, e_tmo, e_we;
   logic [31:0] e_data = 32'h0, e_addr, e_wdata;
   logic [3:0]  e_be;

   // Observations used by the literal checks.
   int          n_req = 0, n_dv = 0, n_err = 0, n_tmo = 0;
   logic [31:0] last_addr, last_wdata;
   logic [3:0]  last_be;
   logic        last_we;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus_req_o) begin
         n_req++;
         last_addr  = bus_addr_o;
         last_wdata = bus_wdata_o;
         last_be    = bus_be_o;
         last_we    = bus_we_o;
      end
      if (data_valid_o) n_dv++;
      if (acc_err_o) n_err++;
      if (timeout_o) n_tmo++;
      if (e_chk) begin
         chk("stall", 32'(stall_o), 32'(e_stall));
         chk("bus_req", 32'(bus_req_o), 32'(e_req));
         chk("data_valid", 32'(data_valid_o), 32'(e_dv));
         chk("acc_err", 32'(acc_err_o), 32'(e_err));
         chk("timeout", 32'(timeout_o), 32'(e_tmo));
         chk("data_r", data_r_o, e_data);
         if (e_req) begin
            chk("bus_we", 32'(bus_we_o), 32'(e_we));
            chk("bus_addr", bus_addr_o, e_addr);
            if (e_we) begin
               chk("bus_wdata", bus_wdata_o, e_wdata);
               chk("bus_be", 32'(bus_be_o), 32'(e_be));
            end else begin
               chk("bus_be_load", 32'(bus_be_o), 32'h0);
            end
         end
      end
   end

   task automatic idle_exp();
      e_stall = 1'b0; e_req = 1'b0; e_dv = 1'b0; e_err = 1'b0; e_tmo = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle_exp();
   endtask

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] rd);
      logic [31:0] t;
      int          s;
      case (f3)
         3'b000, 3'b100: t = rd << (8 * (3 - int'(off)));
         3'b001, 3'b101: t = rd << (16 * (1 - int'(off[1])));
         default:        t = rd;
      endcase
      s = t;
      case (f3)
         3'b000:  return s >>> 24;
         3'b100:  return t >> 24;
         3'b001:  return s >>> 16;
         3'b101:  return t >> 16;
         default: return rd;
      endcase
   endfunction

   function automatic bit ref_legal(input logic we, input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         3'b000:  return 1'b1;
         3'b001:  return off[0] == 1'b0;
         3'b010:  return off == 2'b00;
         3'b100:  return !we;
         3'b101:  return !we && off[0] == 1'b0;
         default: return 1'b0;
      endcase
   endfunction

   // Entered and left at posedge+1; g = cycles in REQ before gnt, r = cycles in
   // WAIT_R before rvalid, spur = throw stray rvalids at the REQ state.
   task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int g, input int r, input bit spur);
      bit legal, tmo;
      int n, nreq, lim;
      logic [1:0] off;
      off   = addr[1:0];
      legal = ref_legal(we, f3, off);
      req_valid_i = 1'b1; mem_we_i = we; funct3_i = f3; addr_i = addr; wdata_i = wdata;
      e_stall = legal;
      step();
      req_valid_i = 1'b0; mem_we_i = $urandom; funct3_i = $urandom;
      addr_i = $urandom; wdata_i = $urandom;
      if (!legal) begin
         e_err = 1'b1;
         step();
         return;
      end
      if (g > T - 1) begin
         tmo = 1; n = T; nreq = T;
      end else if (we) begin
         tmo = 0; n = g + 1; nreq = g + 1;
      end else begin
         nreq = g + 1;
         lim  = (T - 1 > g + 1) ? T - 1 : g + 1;
         if (g + 1 + r <= lim) begin tmo = 0; n = g + 2 + r; end
         else begin tmo = 1; n = lim + 1; end
      end
      e_we    = we;
      e_addr  = {addr[31:2], 2'b00};
      case (f3)
         3'b000:  begin e_wdata = 32'(wdata[7:0]) * 32'h0101_0101; e_be = 4'(1 << off); end
         3'b001:  begin e_wdata = 32'(wdata[15:0]) * 32'h0001_0001;
                        e_be = off[1] ? 4'hC : 4'h3; end
         default: begin e_wdata = wdata; e_be = 4'hF; end
      endcase
      for (int k = 0; k < n; k++) begin
         bus_gnt_i    = (k == g);
         bus_rvalid_i = (!we && k == g + 1 + r) || (spur && k < g && $urandom_range(1, 0) == 1);
         bus_rdata_i  = (k == g + 1 + r) ? rdata : $urandom;
         e_stall = 1'b1;
         e_req   = (k < nreq);
         step();
      end
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = $urandom;
      e_tmo = tmo;
      e_dv  = !we && !tmo;
      if (tmo) e_data = 32'h0;
      else if (!we) e_data = ref_load(f3, off, rdata);
      step();
   endtask

   initial begin
      int dv0, req0, err0, tmo0;
      repeat (3) @(posedge clk);
      #1;
      rst_i = 1'b0;
      idle_exp();
      e_data = 32'h0;
      e_chk  = 1'b1;
      #4;
      chk("reset_data_r", data_r_o, 32'h0);
      chk("reset_outs", {31'h0, stall_o | bus_req_o | data_valid_o | acc_err_o | timeout_o |
                         bus_we_o | (|bus_be_o) | (|bus_addr_o)}, 32'h0);
      step();

      // LW with gnt and rvalid back to back.
      run_txn(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0);
      chk("lw_lit", data_r_o, 32'hDEADBEEF);
      run_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1, 2, 1);
      chk("lb_lit", data_r_o, 32'hFFFFFF80);
      run_txn(1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0, 1, 0);
      chk("lbu_lit", data_r_o, 32'h00000080);
      run_txn(1'b0, 3'b101, 32'h102, 32'h0, 32'h80112233, 2, 0, 1);
      chk("lhu_lit", data_r_o, 32'h00008011);

      dv0 = n_dv;
      run_txn(1'b1, 3'b000, 32'h201, 32'h000000A5, 32'h0, 1, 0, 0);
      chk("sb_addr", last_addr, 32'h200);
      chk("sb_wdata", last_wdata, 32'hA5A5A5A5);
      chk("sb_be", 32'(last_be), 32'h2);
      chk("sb_we", 32'(last_we), 32'h1);
      chk("sb_no_dv", n_dv - dv0, 0);

      req0 = n_req; err0 = n_err;
      run_txn(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0, 0);
      chk("mis_no_req", n_req - req0, 0);
      chk("mis_err", n_err - err0, 1);
      chk("mis_data_kept", data_r_o, 32'h00008011);

      req0 = n_req; tmo0 = n_tmo;
      run_txn(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 50, 0, 0);
      chk("tmo_req_cycles", n_req - req0, T);
      chk("tmo_pulse", n_tmo - tmo0, 1);
      chk("tmo_data", data_r_o, 32'h0);
      chk("tmo_idle", 32'(stall_o | bus_req_o), 32'h0);

      // Reset while waiting for read data, then a late rvalid.
      run_txn(1'b0, 3'b010, 32'h500, 32'h0, 32'h13572468, 0, 0, 0);
      req_valid_i = 1'b1; mem_we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h300;
      e_stall = 1'b1;
      step();
      req_valid_i = 1'b0;
      bus_gnt_i = 1'b1; e_stall = 1'b1; e_req = 1'b1; e_we = 1'b0; e_addr = 32'h300;
      step();
      bus_gnt_i = 1'b0; rst_i = 1'b1; e_stall = 1'b1;
      step();
      rst_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hCAFEF00D;
      e_data = 32'h0;
      dv0 = n_dv;
      step();
      bus_rvalid_i = 1'b0;
      step();
      chk("rst_no_dv", n_dv - dv0, 0);
      chk("rst_data", data_r_o, 32'h0);
      chk("rst_no_req", 32'(bus_req_o), 32'h0);

      for (int i = 0; i < 80; i++) begin
         logic [2:0]  f3;
         logic        we;
         logic [31:0] a;
         we = $urandom_range(1, 0);
         f3 = 3'($urandom_range(7, 0));
         a  = $urandom;
         if ($urandom_range(3, 0) != 0) begin
            if (f3 == 3'b010) a[1:0] = 2'b00;
            else if (f3[1:0] == 2'b01) a[0] = 1'b0;
         end
         run_txn(we, f3, a, $urandom, $urandom, $urandom_range(9, 0),
                 $urandom_range(6, 0), 1'($urandom_range(1, 0)));
         repeat ($urandom_range(1, 0)) step();
      end

      step();
      e_chk = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
